// File: rtl/make_go_fast_hls_deadlock_pkg.sv
// make_go_fast_hls_deadlock_pkg: shared state encodings and width helper for the deadlock report unit
package make_go_fast_hls_deadlock_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ORIGIN, S_TRACE, S_REPORT, S_DONE} state_e;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/make_go_fast_hls_deadlock_prio_enc.sv
// make_go_fast_hls_deadlock_prio_enc: lowest-set-bit encoder, index 0 has priority
module make_go_fast_hls_deadlock_prio_enc #(
    parameter int PROC_NUM = 4,
    parameter int IDX_W    = 2
) (
    input  logic [PROC_NUM-1:0] vec,
    output logic [IDX_W-1:0]    idx,
    output logic [PROC_NUM-1:0] onehot
);
    always_comb begin
        idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) if (vec[i]) idx = IDX_W'(i);
        onehot = vec & (~vec + 1'b1);
    end
endmodule

// File: rtl/make_go_fast_hls_deadlock_report_unit.sv
// make_go_fast_hls_deadlock_report_unit: latches the first deadlock, launches the token trace
// from one origin, collects the processes on the cycle and reports them over valid/ready
module make_go_fast_hls_deadlock_report_unit
    import make_go_fast_hls_deadlock_pkg::*;
#(
    parameter int PROC_NUM      = 4,
    parameter int TRACE_TIMEOUT = 64,
    parameter int IDX_W         = (clog2(PROC_NUM) > 1) ? clog2(PROC_NUM) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [IDX_W-1:0]    report_idx,
    output logic [PROC_NUM-1:0] report_vec,
    output logic                report_timeout
);
    localparam int TIMER_W = clog2(TRACE_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    enc_idx, idx_q, idx_d;
    logic [PROC_NUM-1:0] enc_onehot, vec_q, vec_d, origin_q, origin_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                dl_q, dl_d, timeout_q, timeout_d, tok_ret, timer_end;

    make_go_fast_hls_deadlock_prio_enc #(.PROC_NUM(PROC_NUM), .IDX_W(IDX_W)) u_enc (
        .vec    (dl_in_vec),
        .idx    (enc_idx),
        .onehot (enc_onehot)
    );

    assign tok_ret   = dl_in_vec[idx_q];
    assign timer_end = timer_q == TIMER_W'(TRACE_TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vec_d       = vec_q;
        timer_d     = timer_q;
        dl_d        = dl_q;
        timeout_d   = timeout_q;
        origin_d    = '0;
        token_clear = 1'b0;
        case (state_q)
            S_IDLE: if (|dl_in_vec) begin
                idx_d    = enc_idx;
                vec_d    = enc_onehot;
                origin_d = enc_onehot;
                dl_d     = 1'b1;
                state_d  = S_ORIGIN;
            end
            S_ORIGIN: begin
                timer_d = '0;
                state_d = S_TRACE;
            end
            S_TRACE: begin
                vec_d       = vec_q | dl_in_vec;
                token_clear = tok_ret | timer_end;
                if (tok_ret | timer_end) begin
                    timeout_d = ~tok_ret;
                    state_d   = S_REPORT;
                end else timer_d = timer_q + 1'b1;
            end
            S_REPORT: if (report_ready) state_d = S_DONE;
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
    end

    // origin is a register so the strobe is a clean one-cycle pulse while in ORIGIN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            vec_q     <= '0;
            timer_q   <= '0;
            dl_q      <= 1'b0;
            timeout_q <= 1'b0;
            origin_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vec_q     <= vec_d;
            timer_q   <= timer_d;
            dl_q      <= dl_d;
            timeout_q <= timeout_d;
            origin_q  <= origin_d;
        end
    end

    assign dl_detect_out  = dl_q;
    assign origin         = origin_q;
    assign report_valid   = state_q == S_REPORT;
    assign report_idx     = idx_q;
    assign report_vec     = vec_q;
    assign report_timeout = timeout_q;
endmodule

// File: tb/tb_make_go_fast_hls_deadlock_report_unit.sv
// tb_make_go_fast_hls_deadlock_report_unit: directed checks of detect, trace, timeout, backpressure and DONE
module tb_make_go_fast_hls_deadlock_report_unit;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] dl_in_vec;
    logic       dl_detect_out;
    logic [3:0] origin;
    logic       token_clear;
    logic       report_valid;
    logic       report_ready;
    logic [1:0] report_idx;
    logic [3:0] report_vec;
    logic       report_timeout;
    int         passed = 0;
    int         total = 0;

    make_go_fast_hls_deadlock_report_unit #(.PROC_NUM(4), .TRACE_TIMEOUT(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .dl_in_vec      (dl_in_vec),
        .dl_detect_out  (dl_detect_out),
        .origin         (origin),
        .token_clear    (token_clear),
        .report_valid   (report_valid),
        .report_ready   (report_ready),
        .report_idx     (report_idx),
        .report_vec     (report_vec),
        .report_timeout (report_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        dl_in_vec = '0;
        report_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        dl_in_vec = '0;
        report_ready = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        check("rst_detect", dl_detect_out, 0);
        check("rst_origin", origin, 0);
        check("rst_tc", token_clear, 0);
        check("rst_valid", report_valid, 0);
        check("rst_idx", report_idx, 0);
        check("rst_vec", report_vec, 0);
        check("rst_timeout", report_timeout, 0);
        reset = 1'b0;
        // simultaneous detect picks the lowest index
        dl_in_vec = 4'b1010;
        #1;
        check("det_pre", dl_detect_out, 0);
        tick();
        dl_in_vec = '0;
        #1;
        check("det_flag", dl_detect_out, 1);
        check("det_origin", origin, 4'b0010);
        check("det_idx", report_idx, 1);
        tick();
        #1;
        check("origin_once", origin, 0);
        check("det_sticky", dl_detect_out, 1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_detect", dl_detect_out, 0);
        check("mid_rst_vec", report_vec, 0);
        check("mid_rst_valid", report_valid, 0);
        tick();
        check("mid_rst_hold", dl_detect_out, 0);
        reset = 1'b0;
        // token return to origin 2
        dl_in_vec = 4'b0100;
        tick();
        dl_in_vec = 4'b0010;
        #1;
        check("ret_origin", origin, 4'b0100);
        check("ret_tc_origin", token_clear, 0);
        tick();
        dl_in_vec = 4'b1000;
        #1;
        check("ret_tc0", token_clear, 0);
        tick();
        dl_in_vec = 4'b0001;
        #1;
        check("ret_tc1", token_clear, 0);
        tick();
        dl_in_vec = 4'b0100;
        #1;
        check("ret_tc2", token_clear, 1);
        tick();
        dl_in_vec = '0;
        #1;
        check("ret_valid", report_valid, 1);
        check("ret_idx", report_idx, 2);
        check("ret_vec", report_vec, 4'b1101);
        check("ret_timeout", report_timeout, 0);
        check("ret_tc_after", token_clear, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", report_valid, 1);
            check("bp_vec", report_vec, 4'b1101);
            check("bp_idx", report_idx, 2);
            check("bp_timeout", report_timeout, 0);
        end
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        #1;
        check("done_valid", report_valid, 0);
        check("done_detect", dl_detect_out, 1);
        check("done_vec", report_vec, 4'b1101);
        for (int i = 0; i < 4; i++) begin
            dl_in_vec = i[0] ? 4'b0000 : 4'b1111;
            #1;
            check("imm_origin", origin, 0);
            check("imm_tc", token_clear, 0);
            check("imm_valid", report_valid, 0);
            tick();
        end
        check("imm_detect", dl_detect_out, 1);
        // timeout with origin 0 and no returning token
        pulse_reset();
        dl_in_vec = 4'b0001;
        tick();
        dl_in_vec = '0;
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            check("to_tc", token_clear, 32'(i == 7));
            check("to_valid", report_valid, 0);
            if (i == 7) report_ready = 1'b1;
            tick();
        end
        #1;
        check("to_valid_rep", report_valid, 1);
        check("to_timeout", report_timeout, 1);
        check("to_vec", report_vec, 4'b0001);
        check("to_idx", report_idx, 0);
        tick();
        check("to_ready_entry", report_valid, 0);
        report_ready = 1'b0;
        // token return coincides with the last timer cycle
        pulse_reset();
        dl_in_vec = 4'b1000;
        tick();
        dl_in_vec = '0;
        tick();
        repeat (7) tick();
        dl_in_vec = 4'b1000;
        #1;
        check("tie_tc", token_clear, 1);
        tick();
        dl_in_vec = '0;
        #1;
        check("tie_valid", report_valid, 1);
        check("tie_timeout", report_timeout, 0);
        check("tie_vec", report_vec, 4'b1000);
        check("tie_idx", report_idx, 3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
